// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell, LSB first, registered carry; optional SERIAL_ADD_OVERFLOW_EN adds a signed-overflow output.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH; one result per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; a start in the DONE cycle is taken back-to-back.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_a, shift_b, shift_s, shift_s_nxt;
    logic             carry_q;
    logic [CW-1:0]    bit_cnt;
    logic             accept, last_bit, s_bit, c_bit;

    assign s_bit    = shift_a[0] ^ shift_b[0] ^ carry_q;
    assign c_bit    = (shift_a[0] & shift_b[0]) | (carry_q & (shift_a[0] ^ shift_b[0]));
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shift_s_nxt = s_bit;
        end else begin : g_wn
            assign shift_s_nxt = {s_bit, shift_s[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                if (start) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                accept    = start;
                state_nxt = start ? ADD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_a   <= '0;
            shift_b   <= '0;
            shift_s   <= '0;
            carry_q   <= 1'b0;
            bit_cnt   <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else if (accept) begin
            shift_a <= a;
            shift_b <= b;
            carry_q <= carry_in;
            bit_cnt <= '0;
        end else if (busy) begin
            shift_a <= shift_a >> 1;
            shift_b <= shift_b >> 1;
            shift_s <= shift_s_nxt;
            carry_q <= c_bit;
            bit_cnt <= bit_cnt + CW'(1);
            // Outputs update only here, so they never show a partial result.
            if (last_bit) begin
                sum       <= shift_s_nxt;
                carry_out <= c_bit;
`ifdef SERIAL_ADD_OVERFLOW_EN
                overflow  <= carry_q ^ c_bit;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised + directed bench for serial_adder_ctrl (WIDTH=8 scoreboard, WIDTH=1 truth table).
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk, reset;
    logic         start8, ci8, busy8, done8, cout8;
    logic [W-1:0] a8, b8, sum8;
    logic         start1, ci1, busy1, done1, cout1;
    logic [0:0]   a1, b1, sum1;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic         ovf8, ovf1;
`endif

    serial_adder_ctrl #(.WIDTH(W)) u8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .carry_in(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
`ifdef SERIAL_ADD_OVERFLOW_EN
        , .overflow(ovf8)
`endif
    );

    serial_adder_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .carry_in(ci1),
        .busy(busy1), .done(done1), .sum(sum1), .carry_out(cout1)
`ifdef SERIAL_ADD_OVERFLOW_EN
        , .overflow(ovf1)
`endif
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           dcyc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_err = 0;
    logic         chk_en = 1'b0;
    logic [W-1:0] hold_s = '0;
    logic         hold_c = 1'b0;
    logic         hold_o = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/carry, signed range for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input int dc);
        exp_t        e;
        logic [W:0]  t;
        int          r;
        t = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        r = int'($signed(x)) + int'($signed(y)) + int'(ci);
        e.s    = t[W-1:0];
        e.c    = t[W];
        e.o    = (r > 127) || (r < -128);
        e.dcyc = dc;
        return e;
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; the start is taken on the next edge.
    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        a8 = ia; b8 = ib; ci8 = ic; start8 = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model(ia, ib, ic, cyc + W));
        start8 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        ci8 = 1'($urandom);
    endtask

    // Monitor: compares busy/done timing, results on done, and held outputs otherwise.
    initial begin
        exp_t e;
        logic exp_busy, exp_done;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_busy = 1'b0;
                exp_done = 1'b0;
                if (q.size() != 0) begin
                    exp_busy = (cyc >= q[0].dcyc - W) && (cyc < q[0].dcyc);
                    exp_done = (cyc == q[0].dcyc);
                end
                chk("busy8", 32'(busy8), 32'(exp_busy));
                chk("done8", 32'(done8), 32'(exp_done));
                if (exp_done) begin
                    e = q.pop_front();
                    hold_s = e.s;
                    hold_c = e.c;
                    hold_o = e.o;
                end
                chk("sum8", 32'(sum8), 32'(hold_s));
                chk("cout8", 32'(cout8), 32'(hold_c));
`ifdef SERIAL_ADD_OVERFLOW_EN
                chk("ovf8", 32'(ovf8), 32'(hold_o));
`endif
            end
            if (reset) begin
                q.delete();
                hold_s = '0;
                hold_c = 1'b0;
                hold_o = 1'b0;
            end
        end
    end

    initial begin
        logic [1:0] t1;
        int         r1;
        int         guard;
        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        wait_edges(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_sum8", 32'(sum8), 0);
        chk("rst_cout8", 32'(cout8), 0);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_sum1", 32'(sum1), 0);
`ifdef SERIAL_ADD_OVERFLOW_EN
        chk("rst_ovf8", 32'(ovf8), 0);
`endif
        chk_en = 1'b1;
        wait_edges(1);

        // WIDTH=1: full-adder truth table
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); ci1 = 1'(i);
            t1 = 2'(a1) + 2'(b1) + 2'(ci1);
            r1 = -int'(a1) - int'(b1) + int'(ci1);
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            @(negedge clk);
            chk("w1_busy", 32'(busy1), 1);
            chk("w1_early_done", 32'(done1), 0);
            @(negedge clk);
            chk("w1_done", 32'(done1), 1);
            chk("w1_sum", 32'(sum1), 32'(t1[0]));
            chk("w1_cout", 32'(cout1), 32'(t1[1]));
`ifdef SERIAL_ADD_OVERFLOW_EN
            chk("w1_ovf", 32'(ovf1), 32'((r1 > 0) || (r1 < -1)));
`endif
            wait_edges(1);
        end

        // directed WIDTH=8 cases
        start_op(8'hFF, 8'h01, 1'b0);
        wait_edges(W + 1);
        start_op(8'hA5, 8'h5A, 1'b1);
        wait_edges(W);
        start_op(8'h12, 8'h34, 1'b0);
        wait_edges(W + 1);

        start_op(8'h0F, 8'h01, 1'b0);
        wait_edges(2);
        a8 = 8'hFF; start8 = 1'b1;
        wait_edges(1);
        start8 = 1'b0;
        wait_edges(W - 2);

        start_op(8'h55, 8'h66, 1'b0);
        wait_edges(3);
        reset = 1'b1;
        wait_edges(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy8), 0);
        chk("midrst_done", 32'(done8), 0);
        chk("midrst_sum", 32'(sum8), 0);
        chk("midrst_cout", 32'(cout8), 0);
        wait_edges(W + 2);
        start_op(8'h03, 8'h04, 1'b0);
        wait_edges(W + 1);

        start_op(8'h7F, 8'h01, 1'b0);
        wait_edges(W + 1);
        start_op(8'hFF, 8'h01, 1'b0);
        wait_edges(W + 1);

        // random operands, random spacing including back-to-back
        for (int i = 0; i < 40; i++) begin
            start_op(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) wait_edges(W);
            else wait_edges(W + 1 + $urandom_range(0, 3));
        end

        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_empty", 32'(q.size()), 0);
        wait_edges(3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
